// File: rtl/div_unit.sv
// ============================================================================
//  Module      : div_unit
//  Description : Iterative 32-bit restoring divider for the EX stage.
//                Accepts a request while start_i is high, runs one
//                shift-subtract step per clock over 32 clocks, then presents
//                {remainder, quotient} with ready_o until start_i drops.
//                annul_i cancels an in-flight division. Divide-by-zero
//                finishes early with an all-zero result.
//  Revision    : 1.0 - initial release
//
//  Configuration macro:
//    DIV_SIGNED_EN - when defined, adds signed_div_i and the sign handling
//                    (magnitude conversion at accept, result fix-up at end).
//                    When undefined, the unit is unsigned only.
//
//  Ports:
//    clk          in   1  rising-edge clock
//    rst          in   1  synchronous active-high reset
//    start_i      in   1  division request, held until ready_o is seen
//    annul_i      in   1  cancel in-flight division (pipeline flush)
//    opdata1_i    in  32  dividend
//    opdata2_i    in  32  divisor
//    signed_div_i in   1  signed division select (DIV_SIGNED_EN only)
//    result_o     out 64  {remainder[63:32], quotient[31:0]}, registered
//    ready_o      out  1  result valid, registered
// ============================================================================
`default_nettype none

module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        annul_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
`ifdef DIV_SIGNED_EN
    input  logic        signed_div_i,
`endif
    output logic [63:0] result_o,
    output logic        ready_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BYZERO = 2'd1;
    localparam logic [1:0] S_ON     = 2'd2;
    localparam logic [1:0] S_END    = 2'd3;

    localparam logic [5:0] C_LAST_STEP = 6'd32;

    logic [1:0]  state;
    logic [5:0]  cnt;
    // Partial remainder and quotient share one register:
    // part[64:32] is the running remainder, part[31:0] shifts the dividend
    // out at the top while quotient bits enter at the bottom.
    logic [64:0] part;
    logic [31:0] divisor;

    logic [31:0] mag_dividend;
    logic [31:0] mag_divisor;
    logic [33:0] trial_top;
    logic [33:0] trial_diff;
    logic [64:0] part_next;
    logic [31:0] quot_final;
    logic [31:0] rem_final;

`ifdef DIV_SIGNED_EN
    logic        neg_quot;
    logic        neg_rem;
    logic        take_neg_quot;
    logic        take_neg_rem;
`endif

    // ------------------------------------------------------------------
    // Operand conditioning and one restoring step
    // ------------------------------------------------------------------
    always_comb begin
`ifdef DIV_SIGNED_EN
        take_neg_quot = signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
        take_neg_rem  = signed_div_i & opdata1_i[31];
        mag_dividend  = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
        mag_divisor   = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
`else
        mag_dividend  = opdata1_i;
        mag_divisor   = opdata2_i;
`endif
        // Remainder shifted left by one with the next dividend bit brought
        // in; the top bit is always zero because remainder < divisor.
        trial_top  = part[64:31];
        trial_diff = trial_top - {2'b00, divisor};
        if (!trial_diff[33]) begin
            part_next = {trial_diff[32:0], part[30:0], 1'b1};
        end else begin
            part_next = {part[63:0], 1'b0};
        end

`ifdef DIV_SIGNED_EN
        quot_final = neg_quot ? (~part[31:0] + 32'd1)  : part[31:0];
        rem_final  = neg_rem  ? (~part[63:32] + 32'd1) : part[63:32];
`else
        quot_final = part[31:0];
        rem_final  = part[63:32];
`endif
    end

    // ------------------------------------------------------------------
    // Control FSM and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= 6'd0;
            part     <= 65'd0;
            divisor  <= 32'd0;
            result_o <= 64'd0;
            ready_o  <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_quot <= 1'b0;
            neg_rem  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    ready_o  <= 1'b0;
                    result_o <= 64'd0;
                    if (start_i && !annul_i) begin
                        // Operands are captured here only; later changes on
                        // the inputs cannot disturb the running division.
                        part    <= {33'd0, mag_dividend};
                        divisor <= mag_divisor;
                        cnt     <= 6'd0;
`ifdef DIV_SIGNED_EN
                        neg_quot <= take_neg_quot;
                        neg_rem  <= take_neg_rem;
`endif
                        state   <= (opdata2_i == 32'd0) ? S_BYZERO : S_ON;
                    end
                end

                S_BYZERO: begin
                    result_o <= 64'd0;
                    ready_o  <= 1'b1;
                    state    <= S_END;
                end

                S_ON: begin
                    if (annul_i || !start_i) begin
                        state    <= S_IDLE;
                        cnt      <= 6'd0;
                        ready_o  <= 1'b0;
                        result_o <= 64'd0;
                    end else if (cnt != C_LAST_STEP) begin
                        part <= part_next;
                        cnt  <= cnt + 6'd1;
                    end else begin
                        result_o <= {rem_final, quot_final};
                        ready_o  <= 1'b1;
                        state    <= S_END;
                    end
                end

                S_END: begin
                    // Result is held for as long as the requester keeps
                    // start_i high, giving a stalled EX stage time to read it.
                    if (!start_i) begin
                        state    <= S_IDLE;
                        ready_o  <= 1'b0;
                        result_o <= 64'd0;
                    end
                end

                default: begin
                    state    <= S_IDLE;
                    ready_o  <= 1'b0;
                    result_o <= 64'd0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// ============================================================================
//  Module      : tb_div_unit
//  Description : Directed self-checking bench for div_unit. Covers reset,
//                unsigned results, fixed latency, divide-by-zero, annul,
//                start drop, reset mid-operation and (with DIV_SIGNED_EN)
//                signed results.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        annul_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
`ifdef DIV_SIGNED_EN
    logic        signed_div_i;
`endif
    logic [63:0] result_o;
    logic        ready_o;

    int vectors;
    int miscompares;
    logic seen_ready;

    div_unit dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
`ifdef DIV_SIGNED_EN
        .signed_div_i (signed_div_i),
`endif
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Full transaction: accept on edge 1, ready first high after edge 34,
    // result held while start stays high, cleared one edge after start drops.
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp);
        start_i   = 1'b1;
        opdata1_i = a;
        opdata2_i = b;
        step();                                    // edge 1: accept
        opdata1_i = $urandom;                      // must not matter any more
        opdata2_i = $urandom;
        check({tag, " ready_e1"}, {63'd0, ready_o}, 64'd0);
        repeat (32) step();                        // edges 2..33
        check({tag, " ready_e33"}, {63'd0, ready_o}, 64'd0);
        step();                                    // edge 34
        check({tag, " ready_e34"}, {63'd0, ready_o}, 64'd1);
        check({tag, " result"}, result_o, exp);
        step();                                    // held in END
        check({tag, " hold"}, result_o, exp);
        start_i = 1'b0;
        step();
        check({tag, " ready_drop"}, {63'd0, ready_o}, 64'd0);
        check({tag, " result_drop"}, result_o, 64'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        start_i     = 1'b0;
        annul_i     = 1'b0;
        opdata1_i   = 32'd0;
        opdata2_i   = 32'd0;
`ifdef DIV_SIGNED_EN
        signed_div_i = 1'b0;
`endif
        repeat (3) step();
        check("reset ready", {63'd0, ready_o}, 64'd0);
        check("reset result", result_o, 64'd0);
        rst = 1'b0;
        step();

        // Unsigned directed vectors
        run_div("100/7",       32'd100,        32'd7,          {32'h00000002, 32'h0000000E});
        run_div("ffff/1",      32'hFFFFFFFF,   32'd1,          {32'h00000000, 32'hFFFFFFFF});
        run_div("8000/3",      32'h80000000,   32'd3,          {32'h00000002, 32'h2AAAAAAA});
        run_div("5/10",        32'd5,          32'd10,         {32'h00000005, 32'h00000000});
        run_div("ffff/ffff",   32'hFFFFFFFF,   32'hFFFFFFFF,   {32'h00000000, 32'h00000001});
        run_div("ffff/2",      32'hFFFFFFFF,   32'd2,          {32'h00000001, 32'h7FFFFFFF});

        // Divide by zero: ready after edge 2, zero result
        start_i   = 1'b1;
        opdata1_i = 32'd1234;
        opdata2_i = 32'd0;
        step();
        check("byzero ready_e1", {63'd0, ready_o}, 64'd0);
        step();
        check("byzero ready_e2", {63'd0, ready_o}, 64'd1);
        check("byzero result", result_o, 64'd0);
        start_i = 1'b0;
        step();
        check("byzero ready_drop", {63'd0, ready_o}, 64'd0);

        // Annul at edge 10
        seen_ready = 1'b0;
        start_i    = 1'b1;
        opdata1_i  = 32'd100;
        opdata2_i  = 32'd7;
        step();
        for (int i = 0; i < 8; i++) begin
            step();
            seen_ready = seen_ready | ready_o;
        end
        annul_i = 1'b1;
        step();                                    // edge 10
        check("annul ready", {63'd0, ready_o}, 64'd0);
        check("annul result", result_o, 64'd0);
        annul_i = 1'b0;
        start_i = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            seen_ready = seen_ready | ready_o;
        end
        check("annul never_ready", {63'd0, seen_ready}, 64'd0);
        run_div("post_annul", 32'd1000, 32'd1000, {32'h00000000, 32'h00000001});

        // Start dropped mid-operation aborts
        start_i   = 1'b1;
        opdata1_i = 32'd50;
        opdata2_i = 32'd3;
        repeat (5) step();
        start_i = 1'b0;
        step();
        check("drop ready", {63'd0, ready_o}, 64'd0);
        repeat (40) step();
        check("drop idle_ready", {63'd0, ready_o}, 64'd0);

        // Reset at edge 20 of an operation
        start_i   = 1'b1;
        opdata1_i = 32'hFFFFFFFF;
        opdata2_i = 32'd1;
        repeat (19) step();
        rst = 1'b1;
        step();                                    // edge 20
        check("rst_mid ready", {63'd0, ready_o}, 64'd0);
        check("rst_mid result", result_o, 64'd0);
        rst     = 1'b0;
        start_i = 1'b0;
        step();
        run_div("post_rst", 32'h80000000, 32'd3, {32'h00000002, 32'h2AAAAAAA});

`ifdef DIV_SIGNED_EN
        signed_div_i = 1'b1;
        run_div("s -7/2", 32'hFFFFFFF9, 32'd2,          {32'hFFFFFFFF, 32'hFFFFFFFD});
        run_div("s 7/-2", 32'd7,        32'hFFFFFFFE,   {32'h00000001, 32'hFFFFFFFD});
        signed_div_i = 1'b0;
        run_div("u fff9/2", 32'hFFFFFFF9, 32'd2,        {32'h00000001, 32'h7FFFFFFC});
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
